// File: rtl/num_to_ascii_field.sv
// num_to_ascii_field
//   Sequential binary-to-ASCII converter for the calculator VGA text line.
//   Converts VALUE_W-bit value into an N_DIGITS-character field, decimal
//   (shift-add-3) or hexadecimal, with leading-zero padding and an overflow
//   fill when the value does not fit. ascii/overflow are double-buffered and
//   only change in the cycle where done is high.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous reset, active-high
//   start    : conversion request, sampled only in IDLE
//   mode     : 0 = decimal, 1 = hexadecimal (latched with start)
//   value    : number to convert (latched with start)
//   busy     : high whenever the FSM is not in IDLE
//   done     : one-cycle completion pulse
//   ascii    : result string, MSB byte is the leftmost character
//   overflow : last result did not fit in N_DIGITS
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last result
// SHIFT  | decimal double-dabble, one value bit per cycle, MSB first
// PAD    | render one digit per cycle into the shadow buffer, left to right
// FINISH | done pulse; ascii/overflow already hold the new result
module num_to_ascii_field #(
  parameter int         VALUE_W  = 16,
  parameter int         N_DIGITS = 6,
  parameter logic [7:0] PAD_CHAR = 8'h20,
  parameter logic [7:0] OVF_CHAR = 8'h23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [VALUE_W-1:0]    value,
  output logic                  busy,
  output logic                  done,
  output logic [8*N_DIGITS-1:0] ascii,
  output logic                  overflow
);

  localparam int D_INT   = (VALUE_W * 3) / 10 + 1;
  localparam int H_INT   = (VALUE_W + 3) / 4;
  localparam int N_REG_A = (D_INT > H_INT) ? D_INT : H_INT;
  // Digit register is wide enough for the full conversion and for the field
  localparam int N_REG   = (N_REG_A > N_DIGITS) ? N_REG_A : N_DIGITS;
  localparam int CNT_W   = $clog2(VALUE_W + 1);
  localparam int IDX_W   = $clog2(N_DIGITS + 1);

  function automatic logic [8*N_DIGITS-1:0] ascii_reset_value();
    logic [8*N_DIGITS-1:0] r;
    for (int i = 0; i < N_DIGITS; i++) r[8*i +: 8] = PAD_CHAR;
    r[7:0] = 8'h30;
    return r;
  endfunction

  localparam logic [8*N_DIGITS-1:0] ASCII_RST = ascii_reset_value();

  typedef enum logic [1:0] {IDLE, SHIFT, PAD, FINISH} state_t;

  state_t                state, state_nxt;
  logic [4*N_REG-1:0]    digits;
  logic [4*N_REG-1:0]    dab;
  logic [4*N_REG-1:0]    hex_load;
  logic [4*H_INT-1:0]    hex_ext;
  logic [VALUE_W-1:0]    val_r;
  logic [CNT_W-1:0]      bit_cnt;
  logic [IDX_W-1:0]      idx;
  logic                  leading;
  logic [8*N_DIGITS-1:0] shadow, shadow_nxt;
  logic [3:0]            cur_digit;
  logic                  emit_pad;
  logic [7:0]            chr;
  logic                  ovf_comb;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = mode ? PAD : SHIFT;
      SHIFT:   if (bit_cnt == CNT_W'(1)) state_nxt = PAD;
      PAD:     if (idx == '0) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
    done = (state == FINISH);
  end

  // Hex nibbles go straight into the digit register, upper digits zero
  always_comb begin
    hex_ext                 = '0;
    hex_ext[VALUE_W-1:0]    = value;
    hex_load                = '0;
    hex_load[4*H_INT-1:0]   = hex_ext;
  end

  // Add-3 correction on every BCD digit before the shift
  always_comb begin
    dab = digits;
    for (int i = 0; i < N_REG; i++) begin
      if (digits[4*i +: 4] >= 4'd5) dab[4*i +: 4] = digits[4*i +: 4] + 4'd3;
    end
  end

  // Any nonzero digit beyond the field means the value does not fit.
  // The digit register is stable throughout PAD, so this is valid there.
  always_comb begin
    ovf_comb = 1'b0;
    for (int i = N_DIGITS; i < N_REG; i++) begin
      if (digits[4*i +: 4] != 4'd0) ovf_comb = 1'b1;
    end
  end

  // Character for the digit under the PAD scan; index 0 is never padded
  always_comb begin
    cur_digit  = digits[4*idx +: 4];
    emit_pad   = leading && (cur_digit == 4'd0) && (idx != '0);
    if (emit_pad)               chr = PAD_CHAR;
    else if (cur_digit < 4'd10) chr = 8'h30 + {4'h0, cur_digit};
    else                        chr = 8'h37 + {4'h0, cur_digit};
    shadow_nxt                = shadow;
    shadow_nxt[8*idx +: 8]    = chr;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      digits   <= '0;
      val_r    <= '0;
      bit_cnt  <= '0;
      idx      <= '0;
      leading  <= 1'b0;
      shadow   <= '0;
      ascii    <= ASCII_RST;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            val_r   <= value;
            leading <= 1'b1;
            idx     <= IDX_W'(N_DIGITS - 1);
            bit_cnt <= CNT_W'(VALUE_W);
            digits  <= mode ? hex_load : '0;
          end
        end
        SHIFT: begin
          digits  <= {dab[4*N_REG-2:0], val_r[VALUE_W-1]};
          val_r   <= val_r << 1;
          bit_cnt <= bit_cnt - CNT_W'(1);
        end
        PAD: begin
          shadow <= shadow_nxt;
          if (!emit_pad) leading <= 1'b0;
          if (idx != '0) begin
            idx <= idx - IDX_W'(1);
          end else begin
            // Load on the edge into FINISH so the result is visible with done
            ascii    <= ovf_comb ? {N_DIGITS{OVF_CHAR}} : shadow_nxt;
            overflow <= ovf_comb;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_num_to_ascii_field.sv
module tb_num_to_ascii_field;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [15:0] value;
  logic        start6, start4, start3;
  logic        busy6, done6, ovf6;
  logic        busy4, done4, ovf4;
  logic        busy3, done3, ovf3;
  logic [47:0] ascii6;
  logic [31:0] ascii4;
  logic [23:0] ascii3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic mon_en = 1'b0;

  typedef struct {
    int          cyc;
    logic [47:0] asc;
    logic        ovf;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  num_to_ascii_field dut6 (
    .clk(clk), .rst(rst), .start(start6), .mode(mode), .value(value),
    .busy(busy6), .done(done6), .ascii(ascii6), .overflow(ovf6)
  );

  num_to_ascii_field #(.N_DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode), .value(value),
    .busy(busy4), .done(done4), .ascii(ascii4), .overflow(ovf4)
  );

  num_to_ascii_field #(.N_DIGITS(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .mode(mode), .value(value),
    .busy(busy3), .done(done3), .ascii(ascii3), .overflow(ovf3)
  );

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor for the 6-digit instance: done must appear exactly
  // in the cycle the head entry predicts, and nowhere else.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() != 0 && q[0].cyc == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("done_pulse", 48'(done6), 48'(1));
        chk("result_ascii", ascii6, e.asc);
        chk("result_ovf", 48'(ovf6), 48'(e.ovf));
        chk("busy_at_done", 48'(busy6), 48'(1));
      end else begin
        chk("no_done", 48'(done6), 48'(0));
      end
    end
  end

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  // Called at #1 after a rising edge; start is high for exactly that cycle
  task automatic start_conv(input logic m, input logic [15:0] v,
                            input logic [47:0] e, input logic o, input int lat);
    start6 = 1'b1;
    mode   = m;
    value  = v;
    q.push_back('{cyc + lat, e, o});
    @(posedge clk); #1;
    start6 = 1'b0;
    mode   = ~m;
    value  = 16'($urandom);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk("drain_timeout", 48'(q.size()), 48'(0));
    q.delete();
  endtask

  task automatic small_run(input int sel, input logic m, input logic [15:0] v,
                           input logic [31:0] e, input logic o, input int lat);
    int t;
    t = cyc;
    mode  = m;
    value = v;
    if (sel == 4) start4 = 1'b1; else start3 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    start3 = 1'b0;
    value  = 16'($urandom);
    for (int k = 0; k < 60; k++) begin
      if ((sel == 4 && done4 === 1'b1) || (sel == 3 && done3 === 1'b1)) break;
      @(posedge clk); #1;
    end
    chk("small_latency", 48'(cyc), 48'(t + lat));
    if (sel == 4) begin
      chk("small4_ascii", 48'(ascii4), 48'(e));
      chk("small4_ovf", 48'(ovf4), 48'(o));
      chk("small4_busy", 48'(busy4), 48'(1));
    end else begin
      chk("small3_ascii", 48'(ascii3), 48'(e[23:0]));
      chk("small3_ovf", 48'(ovf3), 48'(o));
      chk("small3_busy", 48'(busy3), 48'(1));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int t;
    rst    = 1'b1;
    start6 = 1'b0;
    start4 = 1'b0;
    start3 = 1'b0;
    mode   = 1'b0;
    value  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Reset state
    chk("rst_busy", 48'(busy6), 48'(0));
    chk("rst_done", 48'(done6), 48'(0));
    chk("rst_ovf", 48'(ovf6), 48'(0));
    chk("rst_ascii", ascii6, "     0");
    chk("rst_ascii4", 48'(ascii4), 48'("   0"));

    // Decimal
    start_conv(1'b0, 16'd1234, "  1234", 1'b0, 23); drain();
    start_conv(1'b0, 16'd0, "     0", 1'b0, 23); drain();
    start_conv(1'b0, 16'd65535, " 65535", 1'b0, 23); drain();

    // Hex
    start_conv(1'b1, 16'h00AF, "    AF", 1'b0, 7); drain();
    start_conv(1'b1, 16'hFFFF, "  FFFF", 1'b0, 7); drain();

    // Overflow on narrower fields
    small_run(4, 1'b0, 16'd12345, "####", 1'b1, 21);
    small_run(4, 1'b1, 16'h1234, "1234", 1'b0, 5);
    small_run(3, 1'b1, 16'h1234, "###", 1'b1, 4);

    // Busy: a second start mid-conversion is ignored, then back-to-back
    t = cyc;
    start_conv(1'b0, 16'd7, "     7", 1'b0, 23);
    goto(t + 5);
    start6 = 1'b1;
    mode   = 1'b0;
    value  = 16'd99;
    @(posedge clk); #1;
    start6 = 1'b0;
    goto(t + 22);
    chk("hold_ascii", ascii6, "  FFFF");
    chk("hold_busy", 48'(busy6), 48'(1));
    drain();
    start_conv(1'b0, 16'd99, "    99", 1'b0, 23);
    drain();

    // Reset mid-conversion
    t = cyc;
    start6 = 1'b1;
    mode   = 1'b0;
    value  = 16'd500;
    @(posedge clk); #1;
    start6 = 1'b0;
    goto(t + 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_ascii", ascii6, "     0");
    chk("midrst_busy", 48'(busy6), 48'(0));
    chk("midrst_ovf", 48'(ovf6), 48'(0));
    goto(t + 7);
    start_conv(1'b0, 16'd42, "    42", 1'b0, 23);
    drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
